// File: rtl/tzc_sampler.sv
// tzc_sampler: drives an external converter through a soc/eoc handshake,
// reduces each sample to its trailing-zero (or trailing-zero-pair) count and
// publishes the result once per PERIOD-clock window.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for window start (cnt==0) with no unpublished result
// REQ   | soc=1, waiting for the converter to drop eoc (busy)
// ACK   | soc=0, waiting for the converter to raise eoc (sample ready)
// LATCH | one cycle: capture f(x, mode) into res and set done
`default_nettype none

module tzc_sampler #(
  parameter  int W      = 8,
  parameter  int PERIOD = 20,
  localparam int CW     = $clog2(W + 1)
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic [W-1:0]  x,
  input  logic          eoc,
  input  logic          mode,
  output logic          soc,
  output logic [CW-1:0] out,
  output logic          valid,
  output logic          miss
);

  localparam int CNTW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   res_q, res_d;
  logic            done_q, done_d;
  logic            soc_q, soc_d;
  logic [CW-1:0]   out_q, out_d;
  logic            valid_q, valid_d;
  logic            miss_q, miss_d;

  logic            win_start;
  logic            win_end;
  logic [CW-1:0]   tz;
  logic [CW-1:0]   f_val;

  assign win_start = (cnt_q == '0);
  assign win_end   = (cnt_q == CNTW'(PERIOD - 1));

  // Trailing-zero count: index of the lowest set bit, W when x is all zeros.
  always_comb begin
    tz = CW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) tz = CW'(i);
    end
    f_val = mode ? (tz >> 1) : tz;
  end

  // Free-running window counter, independent of the handshake.
  always_comb begin
    cnt_d = win_end ? '0 : cnt_q + CNTW'(1);
  end

  // Handshake FSM; soc is registered from the next state so it is high exactly while in REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_start && !done_q) state_d = ST_REQ;
      ST_REQ:   if (!eoc) state_d = ST_ACK;
      ST_ACK:   if (eoc) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    soc_d = (state_d == ST_REQ);
  end

  // Result capture and window-end publication; a result latched on the
  // window-end cycle itself is only visible to the following window end.
  always_comb begin
    res_d   = res_q;
    done_d  = done_q;
    out_d   = out_q;
    valid_d = 1'b0;
    miss_d  = 1'b0;
    if (win_end) begin
      if (done_q) begin
        out_d   = res_q;
        valid_d = 1'b1;
        done_d  = 1'b0;
      end else begin
        miss_d  = 1'b1;
      end
    end
    if (state_q == ST_LATCH) begin
      res_d  = f_val;
      done_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset_) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      res_q   <= '0;
      done_q  <= 1'b0;
      soc_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      res_q   <= res_d;
      done_q  <= done_d;
      soc_q   <= soc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      miss_q  <= miss_d;
    end
  end

  assign soc   = soc_q;
  assign out   = out_q;
  assign valid = valid_q;
  assign miss  = miss_q;

endmodule

`default_nettype wire
